// File: rtl/write_back_pipe.sv
// write_back_pipe: even/odd result write-back pipelines with latency-slotted issue,
// combinational forwarding, flush and registered structural-hazard flags.
module write_back_pipe #(
    parameter int QUADWORD       = 128,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int DEPTH          = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      res_vld_even,
    input  logic                      res_vld_odd,
    input  logic [2:0]                res_lat_even,
    input  logic [2:0]                res_lat_odd,
    input  logic [REG_ADDR_WIDTH-1:0] res_addr_even,
    input  logic [REG_ADDR_WIDTH-1:0] res_addr_odd,
    input  logic [QUADWORD-1:0]       res_data_even,
    input  logic [QUADWORD-1:0]       res_data_odd,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_addr_b,
    output logic                      fwd_hit_a,
    output logic                      fwd_hit_b,
    output logic [QUADWORD-1:0]       fwd_data_a,
    output logic [QUADWORD-1:0]       fwd_data_b,
    output logic [QUADWORD-1:0]       rt_wt_even,
    output logic [QUADWORD-1:0]       rt_wt_odd,
    output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_even,
    output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_odd,
    output logic                      regWr_en_even,
    output logic                      regWr_en_odd,
    output logic                      collision_even,
    output logic                      collision_odd,
    output logic [4:0]                inflight_cnt
);

    // index 0 is the even pipe, index 1 the odd pipe
    logic                      vld      [2];
    logic [2:0]                lat      [2];
    logic [REG_ADDR_WIDTH-1:0] iss_addr [2];
    logic [QUADWORD-1:0]       iss_data [2];
    logic [REG_ADDR_WIDTH-1:0] fq       [2];
    logic                      fh       [2];
    logic [QUADWORD-1:0]       fd       [2];

    logic [DEPTH:1]            sv [2];
    logic [REG_ADDR_WIDTH-1:0] sa [2][1:DEPTH];
    logic [QUADWORD-1:0]       sd [2][1:DEPTH];
    logic [DEPTH:1]            nv [2];
    logic [REG_ADDR_WIDTH-1:0] na [2][1:DEPTH];
    logic [QUADWORD-1:0]       nd [2][1:DEPTH];

    logic       coll_n [2];
    logic       coll   [2];
    logic [4:0] cnt_n;
    logic [4:0] cnt;

    assign vld[0]      = res_vld_even;
    assign vld[1]      = res_vld_odd;
    assign lat[0]      = res_lat_even;
    assign lat[1]      = res_lat_odd;
    assign iss_addr[0] = res_addr_even;
    assign iss_addr[1] = res_addr_odd;
    assign iss_data[0] = res_data_even;
    assign iss_data[1] = res_data_odd;
    assign fq[0]       = fwd_addr_a;
    assign fq[1]       = fwd_addr_b;

    always_comb begin
        cnt_n = '0;
        for (int p = 0; p < 2; p++) begin
            nv[p][1] = 1'b0;
            na[p][1] = '0;
            nd[p][1] = '0;
            coll_n[p] = vld[p] && (lat[p] == 3'd0 || int'(lat[p]) > DEPTH);
            for (int k = 2; k <= DEPTH; k++) begin
                nv[p][k] = sv[p][k-1];
                na[p][k] = sa[p][k-1];
                nd[p][k] = sd[p][k-1];
                if (vld[p] && int'(lat[p]) == k && sv[p][k-1])
                    coll_n[p] = 1'b1;
            end
            // the issuing entry overrides whatever shifts into its landing stage
            for (int k = 1; k <= DEPTH; k++) begin
                if (vld[p] && int'(lat[p]) == k) begin
                    nv[p][k] = 1'b1;
                    na[p][k] = iss_addr[p];
                    nd[p][k] = iss_data[p];
                end
            end
            // flush drops everything: stage DEPTH's write is already on the outputs this cycle
            if (flush) begin
                nv[p]     = '0;
                coll_n[p] = 1'b0;
            end
            for (int k = 1; k <= DEPTH; k++)
                cnt_n = cnt_n + 5'(nv[p][k]);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sv[p][k] <= !reset && nv[p][k];
                sa[p][k] <= reset ? '0 : na[p][k];
                sd[p][k] <= reset ? '0 : nd[p][k];
            end
            coll[p] <= !reset && coll_n[p];
        end
        cnt <= reset ? '0 : cnt_n;
    end

    // scan oldest to youngest so the lowest matching stage (odd on ties) lands last
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            fh[q] = 1'b0;
            fd[q] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                for (int p = 0; p < 2; p++) begin
                    if (sv[p][k] && sa[p][k] == fq[q]) begin
                        fh[q] = 1'b1;
                        fd[q] = sd[p][k];
                    end
                end
            end
        end
    end

    assign fwd_hit_a       = fh[0];
    assign fwd_hit_b       = fh[1];
    assign fwd_data_a      = fd[0];
    assign fwd_data_b      = fd[1];
    assign rt_wt_even      = sd[0][DEPTH];
    assign rt_wt_odd       = sd[1][DEPTH];
    assign addr_rt_wt_even = sa[0][DEPTH];
    assign addr_rt_wt_odd  = sa[1][DEPTH];
    assign regWr_en_even   = sv[0][DEPTH];
    assign regWr_en_odd    = sv[1][DEPTH];
    assign collision_even  = coll[0];
    assign collision_odd   = coll[1];
    assign inflight_cnt    = cnt;

endmodule

// File: tb/tb_write_back_pipe.sv
// tb_write_back_pipe: table vectors, directed corner sequences and random traffic
// checked against a write-time-slot reference model.
module tb_write_back_pipe;
    localparam int QW = 128;
    localparam int AW = 7;
    localparam int D  = 7;

    logic clk = 1'b0;
    logic reset, flush;
    logic res_vld_even, res_vld_odd;
    logic [2:0] res_lat_even, res_lat_odd;
    logic [AW-1:0] res_addr_even, res_addr_odd, fwd_addr_a, fwd_addr_b;
    logic [QW-1:0] res_data_even, res_data_odd;
    logic fwd_hit_a, fwd_hit_b;
    logic [QW-1:0] fwd_data_a, fwd_data_b, rt_wt_even, rt_wt_odd;
    logic [AW-1:0] addr_rt_wt_even, addr_rt_wt_odd;
    logic regWr_en_even, regWr_en_odd, collision_even, collision_odd;
    logic [4:0] inflight_cnt;

    write_back_pipe #(.QUADWORD(QW), .REG_ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .res_vld_even(res_vld_even), .res_vld_odd(res_vld_odd),
        .res_lat_even(res_lat_even), .res_lat_odd(res_lat_odd),
        .res_addr_even(res_addr_even), .res_addr_odd(res_addr_odd),
        .res_data_even(res_data_even), .res_data_odd(res_data_odd),
        .flush(flush), .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .rt_wt_even(rt_wt_even), .rt_wt_odd(rt_wt_odd),
        .addr_rt_wt_even(addr_rt_wt_even), .addr_rt_wt_odd(addr_rt_wt_odd),
        .regWr_en_even(regWr_en_even), .regWr_en_odd(regWr_en_odd),
        .collision_even(collision_even), .collision_odd(collision_odd),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic live = 1'b0;

    // Model: each pipe is a map from the edge number at which a result is on the
    // write outputs to {addr,data}. Two results sharing a write edge is a collision.
    int n = 0;
    logic          mv [2][64];
    logic [AW-1:0] ma [2][64];
    logic [QW-1:0] md [2][64];
    logic          ec [2];

    typedef struct {
        logic rs, fl, ve; logic [2:0] le; logic [AW-1:0] ae;
        logic vo; logic [2:0] lo; logic [AW-1:0] ao;
        int cnt; logic ce, co, we, wo;
    } vec_t;
    vec_t tbl [13];

    function automatic vec_t vec(int rs, int fl, int ve, int le, int ae, int vo, int lo, int ao,
                                 int cnt, int ce, int co, int we, int wo);
        vec_t v;
        v.rs = rs[0]; v.fl = fl[0]; v.ve = ve[0]; v.le = 3'(le); v.ae = AW'(ae);
        v.vo = vo[0]; v.lo = 3'(lo); v.ao = AW'(ao);
        v.cnt = cnt; v.ce = ce[0]; v.co = co[0]; v.we = we[0]; v.wo = wo[0];
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, n);
        end
    endtask

    task automatic chkd(string nm, logic [QW-1:0] act, logic [QW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, n);
        end
    endtask

    task automatic model_edge();
        logic vl [2];
        int lt [2];
        logic [AW-1:0] ad [2];
        logic [QW-1:0] dt [2];
        int w;
        vl[0] = res_vld_even; lt[0] = int'(res_lat_even); ad[0] = res_addr_even; dt[0] = res_data_even;
        vl[1] = res_vld_odd;  lt[1] = int'(res_lat_odd);  ad[1] = res_addr_odd;  dt[1] = res_data_odd;
        ec[0] = 1'b0;
        ec[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                for (int i = 0; i < 64; i++) mv[p][i] = 1'b0;
            end else if (flush) begin
                for (int i = n + 1; i <= n + D; i++) mv[p][i % 64] = 1'b0;
            end else if (vl[p]) begin
                if (lt[p] < 1 || lt[p] > D) ec[p] = 1'b1;
                else begin
                    w = (n + 1 + D - lt[p]) % 64;
                    if (mv[p][w]) ec[p] = 1'b1;
                    mv[p][w] = 1'b1; ma[p][w] = ad[p]; md[p][w] = dt[p];
                end
            end
            mv[p][n % 64] = 1'b0;
        end
        n++;
    endtask

    task automatic chk_regs();
        int s = n % 64;
        int c = 0;
        chk("we_even", int'(regWr_en_even), int'(mv[0][s]));
        chk("we_odd", int'(regWr_en_odd), int'(mv[1][s]));
        if (mv[0][s]) begin
            chk("waddr_even", int'(addr_rt_wt_even), int'(ma[0][s]));
            chkd("wdata_even", rt_wt_even, md[0][s]);
        end
        if (mv[1][s]) begin
            chk("waddr_odd", int'(addr_rt_wt_odd), int'(ma[1][s]));
            chkd("wdata_odd", rt_wt_odd, md[1][s]);
        end
        chk("coll_even", int'(collision_even), int'(ec[0]));
        chk("coll_odd", int'(collision_odd), int'(ec[1]));
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 64; i++) c += int'(mv[p][i]);
        chk("inflight", int'(inflight_cnt), c);
    endtask

    task automatic chk_fwd();
        logic [AW-1:0] qa;
        logic eh;
        logic [QW-1:0] ed;
        for (int q = 0; q < 2; q++) begin
            qa = (q == 0) ? fwd_addr_a : fwd_addr_b;
            eh = 1'b0;
            ed = '0;
            // later write edge means a younger (lower-index) stage
            for (int w = n; w < n + D; w++)
                for (int p = 0; p < 2; p++)
                    if (mv[p][w % 64] && ma[p][w % 64] == qa) begin
                        eh = 1'b1;
                        ed = md[p][w % 64];
                    end
            chk(q == 0 ? "fwd_hit_a" : "fwd_hit_b", int'(q == 0 ? fwd_hit_a : fwd_hit_b), int'(eh));
            chkd(q == 0 ? "fwd_data_a" : "fwd_data_b", q == 0 ? fwd_data_a : fwd_data_b, ed);
        end
    endtask

    task automatic step();
        #1;
        if (live) chk_fwd();
        @(posedge clk);
        model_edge();
        #1;
        chk_regs();
        live = 1'b1;
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0; res_vld_even = 1'b0; res_vld_odd = 1'b0;
    endtask

    task automatic iss(int p, int l, int a, logic [QW-1:0] d);
        if (p == 0) begin
            res_vld_even = 1'b1; res_lat_even = 3'(l); res_addr_even = AW'(a); res_data_even = d;
        end else begin
            res_vld_odd = 1'b1; res_lat_odd = 3'(l); res_addr_odd = AW'(a); res_data_odd = d;
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 64; i++) mv[p][i] = 1'b0;
        idle();
        res_lat_even = 3'd0; res_lat_odd = 3'd0; res_addr_even = '0; res_addr_odd = '0;
        res_data_even = '0; res_data_odd = '0; fwd_addr_a = '0; fwd_addr_b = '0;

        //           rs fl ve le ae vo lo ao cnt ce co we wo
        tbl[0]  = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = vec(0, 0, 1, 7, 3, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[2]  = vec(0, 0, 1, 0, 1, 1, 7, 4, 1, 1, 0, 0, 1);
        tbl[3]  = vec(0, 0, 0, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0);
        tbl[4]  = vec(0, 0, 1, 2, 5, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[5]  = vec(0, 0, 1, 3, 7, 0, 0, 0, 2, 1, 0, 0, 0);
        tbl[6]  = vec(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[7]  = vec(0, 0, 0, 0, 0, 1, 5, 8, 2, 0, 1, 0, 0);
        tbl[8]  = vec(0, 1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = vec(0, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 1);
        tbl[11] = vec(0, 0, 0, 0, 0, 1, 7, 2, 1, 0, 0, 0, 1);
        tbl[12] = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rs; flush = tbl[i].fl;
            res_vld_even = tbl[i].ve; res_lat_even = tbl[i].le; res_addr_even = tbl[i].ae;
            res_data_even = {16{1'b0, tbl[i].ae}};
            res_vld_odd = tbl[i].vo; res_lat_odd = tbl[i].lo; res_addr_odd = tbl[i].ao;
            res_data_odd = {16{1'b1, tbl[i].ao}};
            step();
            chk("tbl_cnt", int'(inflight_cnt), tbl[i].cnt);
            chk("tbl_coll_even", int'(collision_even), int'(tbl[i].ce));
            chk("tbl_coll_odd", int'(collision_odd), int'(tbl[i].co));
            chk("tbl_we_even", int'(regWr_en_even), int'(tbl[i].we));
            chk("tbl_we_odd", int'(regWr_en_odd), int'(tbl[i].wo));
        end

        // L=2 issue is on the write outputs after the sixth edge, then the pipe drains
        do_reset();
        iss(0, 2, 5, {16{8'hAA}});
        step();
        idle();
        for (int e = 2; e <= 7; e++) begin
            step();
            chk("l2_we", int'(regWr_en_even), int'(e == 6));
            if (e == 6) begin
                chk("l2_addr", int'(addr_rt_wt_even), 5);
                chkd("l2_data", rt_wt_even, {16{8'hAA}});
            end
        end
        chk("l2_drain", int'(inflight_cnt), 0);

        // forwarding: odd wins a same-stage tie; lowest stage wins otherwise
        do_reset();
        iss(0, 3, 9, {16{8'hE0}});
        iss(1, 3, 9, {16{8'h0D}});
        step();
        idle();
        fwd_addr_a = 7'd9; fwd_addr_b = 7'd10;
        #1;
        chk("fwd_tie_hit", int'(fwd_hit_a), 1);
        chkd("fwd_tie_data", fwd_data_a, {16{8'h0D}});
        chk("fwd_miss_hit", int'(fwd_hit_b), 0);
        chkd("fwd_miss_data", fwd_data_b, '0);
        do_reset();
        iss(0, 4, 9, {16{8'h5A}});
        step();
        idle();
        step();
        step();
        #1;
        chkd("fwd_s6", fwd_data_a, {16{8'h5A}});
        iss(1, 2, 9, {16{8'h77}});
        step();
        idle();
        #1;
        chkd("fwd_low", fwd_data_a, {16{8'h77}});

        // flush keeps only the write already on the outputs
        do_reset();
        iss(1, 2, 1, {16{8'h11}});
        iss(0, 3, 2, {16{8'h22}});
        step();
        idle();
        iss(0, 7, 3, {16{8'h33}});
        step();
        chk("fl_cnt3", int'(inflight_cnt), 3);
        chk("fl_wr_addr", int'(addr_rt_wt_even), 3);
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_cnt0", int'(inflight_cnt), 0);
        for (int e = 0; e < D; e++) begin
            step();
            chk("fl_no_we", int'(regWr_en_even | regWr_en_odd), 0);
        end

        // reset with four entries in flight
        iss(0, 2, 4, {16{8'h44}}); iss(1, 3, 5, {16{8'h55}});
        step();
        iss(0, 4, 6, {16{8'h66}}); iss(1, 5, 7, {16{8'h77}});
        step();
        chk("rs_cnt4", int'(inflight_cnt), 4);
        do_reset();
        chk("rs_cnt0", int'(inflight_cnt), 0);
        for (int e = 0; e < D; e++) begin
            step();
            chk("rs_no_we", int'(regWr_en_even | regWr_en_odd), 0);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            res_vld_even = ($urandom_range(0, 9) < 6);
            res_vld_odd = ($urandom_range(0, 9) < 6);
            res_lat_even = 3'($urandom_range(0, 7));
            res_lat_odd = 3'($urandom_range(0, 7));
            res_addr_even = AW'($urandom_range(0, 15));
            res_addr_odd = AW'($urandom_range(0, 15));
            res_data_even = {$urandom, $urandom, $urandom, $urandom};
            res_data_odd = {$urandom, $urandom, $urandom, $urandom};
            fwd_addr_a = AW'($urandom_range(0, 15));
            fwd_addr_b = AW'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
